// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// address/instruction widths and reset defaults.
package ifu_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam logic [ILEN-1:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DELIVER = 2'd2,
        ST_HALT    = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ifu_pc_next.sv
// Next-PC selection: sequential PC+4 or the jump target, plus a flag for
// jump targets that are not 4-byte aligned.
module ifu_pc_next
    import ifu_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            misaligned_o
);

    // Select the successor PC; the sum wraps naturally modulo 2^64
    always_comb begin
        pc_next_o    = pc_i + 64'd4;
        misaligned_o = 1'b0;
        if (jump_en_i) begin
            pc_next_o    = jump_addr_i;
            misaligned_o = (jump_addr_i[1:0] != 2'b00);
        end else begin
            pc_next_o    = pc_i + 64'd4;
            misaligned_o = 1'b0;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Multi-cycle fetch unit: REQ -> WAIT -> DELIVER per instruction, advancing
// the PC on commit and stopping for good on ebreak or a misaligned jump.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [ILEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_resp_valid_i,
    input  logic [ILEN-1:0] imem_resp_data_i,
    output logic [ILEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_o,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            break_en_i,
    output logic            halted_o,
    output logic            fault_o,
    output logic [XLEN-1:0] inst_cnt_o
);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] cnt_q, cnt_d;
    logic            halted_q, halted_d;
    logic            fault_q, fault_d;

    logic [XLEN-1:0] pc_next_s;
    logic            misaligned_s;

    ifu_pc_next u_pc_next (
        .pc_i         (pc_q),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .pc_next_o    (pc_next_s),
        .misaligned_o (misaligned_s)
    );

    // State register, PC, instruction register, commit counter and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_REQ;
            pc_q     <= RESET_PC;
            inst_q   <= NOP_INST;
            cnt_q    <= 64'd0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state logic; jump/break/response inputs only matter in their own state
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        case (state_q)
            ST_REQ: begin
                if (imem_req_ready_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid_i) begin
                    inst_d  = imem_resp_data_i;
                    state_d = ST_DELIVER;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DELIVER: begin
                if (inst_ready_i) begin
                    cnt_d = cnt_q + 64'd1;
                    if (break_en_i) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else if (misaligned_s) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                        fault_d  = 1'b1;
                    end else begin
                        pc_d    = pc_next_s;
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_DELIVER;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Outputs come from registered state; handshakes are held low during reset
    always_comb begin
        imem_req_valid_o = (state_q == ST_REQ) && !rst;
        inst_valid_o     = (state_q == ST_DELIVER) && !rst;
        imem_addr_o      = pc_q;
        inst_addr_o      = pc_q;
        if (inst_valid_o) begin
            inst_o = inst_q;
        end else begin
            inst_o = NOP_INST;
        end
        halted_o   = halted_q;
        fault_o    = fault_q;
        inst_cnt_o = cnt_q;
    end

endmodule
